systolic_ctrl: RTL and testbench
================================

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter ARRAY_SIZE, default 4, is N, the side length of the N x N PE array; legal range 2..16.
REQ-002 Parameter KLEN_W, default 8, is the width of the reduction-length input.
REQ-003 Parameter IDX_W, default 8, is the width of each per-lane element index.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one matrix-multiply pass; sampled only in IDLE.
REQ-007 k_len  input  KLEN_W  reduction length K; sampled with start.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 pe_clr  output  1  drives the rst of every PE, clearing accumulators and pipeline registers.
REQ-010 lane_vld  output  N  bit i high means row-i A feeder and column-i B feeder present real data; low means they drive zero.
REQ-011 lane_k  output  N*IDX_W  lane i index field [i*IDX_W +: IDX_W] is the K-index to fetch for lane i.
REQ-012 out_valid  output  1  row out_row of PE out_c results is ready for readout.
REQ-013 out_row  output  clog2(N)  result row index under readout.
REQ-014 out_ready  input  1  consumer accepts the current row.
REQ-015 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, COMPUTE, OUTPUT, and FIN.
REQ-017 IDLE SHALL go to CLEAR on start=1; k_len SHALL be latched into k_reg on that edge.
REQ-018 CLEAR SHALL last exactly 1 cycle with pe_clr=1 and SHALL exit to COMPUTE if k_reg>0, else to OUTPUT.
REQ-019 COMPUTE SHALL run a 10-bit cycle counter t from 0 to k_reg+2N-3 inclusive (k_reg+2N-2 cycles), then go to OUTPUT; this drains so the last MAC at PE(N-1,N-1), at t=k_reg-1+2(N-1), completes.
REQ-020 During COMPUTE, lane_vld[i] SHALL be 1 iff i <= t < i+k_reg (diagonal skew), and lane_k[i] SHALL be t-i when lane_vld[i]=1, else 0.
REQ-021 Outside COMPUTE, lane_vld SHALL be all 0 and lane_k all 0, so PEs accumulate only zero products and out_c holds.
REQ-022 OUTPUT SHALL assert out_valid with out_row starting at 0; on out_valid and out_ready, out_row SHALL increment.
REQ-023 When row N-1 is accepted, OUTPUT SHALL go to FIN; out_valid and out_row SHALL hold unchanged while out_ready=0 (no timeout).
REQ-024 FIN SHALL last 1 cycle with done=1 and SHALL return to IDLE; a start in FIN SHALL be ignored.
REQ-025 A start outside IDLE SHALL be ignored, and k_len changes after latch SHALL have no effect.
REQ-026 pe_clr SHALL be 0 in COMPUTE, OUTPUT, FIN, and IDLE, so results persist in the array after done until the next CLEAR.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from start or out_ready to any output other than through state.

Reset
REQ-028 rst=1 SHALL force IDLE, t=0, k_reg=0, out_row=0, busy=0, done=0, out_valid=0, lane_vld=0, lane_k=0, and pe_clr=1 (held while rst=1, so the array resets with the controller).
REQ-029 rst asserted in any state mid-pass SHALL abort the pass on the next edge with no done pulse; the first cycle after rst release SHALL be IDLE with pe_clr=0.

Verification
REQ-030 N=4, start with k_len=3 -> pe_clr for 1 cycle; COMPUTE for 9 cycles; lane_vld sequence 0001,0011,0111,1110,1100,1000,0000,0000,0000; lane_k[2] = 0,1,2 at t=2,3,4.
REQ-031 N=4, K=3, out_ready held 1 -> out_row 0,1,2,3 on consecutive cycles; done 1 cycle later; total start-to-done = 1+9+4+1 cycles.
REQ-032 out_ready deasserted for 5 cycles at row 2 -> out_row stays 2 with out_valid=1; resumes on out_ready=1; no row is skipped.
REQ-033 k_len=0 -> CLEAR then OUTPUT directly; lane_vld never set; 4 rows read out (all-zero PE results); done pulses.
REQ-034 start pulsed during COMPUTE and during FIN -> ignored; exactly one done per accepted start.
REQ-035 rst at COMPUTE t=5 -> next cycle IDLE, pe_clr=1 while rst is high, no done; a fresh start with K=2 afterwards completes normally in 1+8+4+1 cycles.

Source files
------------

// File: rtl/systolic_ctrl_if.sv
// Control bundle between the systolic-array sequencer and its requester.
// The slave side is the sequencer; the master side issues passes and drains rows.
interface systolic_ctrl_if #(
  parameter int N      = 4,
  parameter int KLEN_W = 8,
  parameter int IDX_W  = 8
);
  logic                 start;
  logic [KLEN_W-1:0]    k_len;
  logic                 busy;
  logic                 pe_clr;
  logic [N-1:0]         lane_vld;
  logic [N*IDX_W-1:0]   lane_k;
  logic                 out_valid;
  logic [$clog2(N)-1:0] out_row;
  logic                 out_ready;
  logic                 done;

  modport master (
    output start, k_len, out_ready,
    input  busy, pe_clr, lane_vld, lane_k,
    input  out_valid, out_row, done
  );

  modport slave (
    input  start, k_len, out_ready,
    output busy, pe_clr, lane_vld, lane_k,
    output out_valid, out_row, done
  );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N output-stationary systolic array:
// clear, skewed feed plus drain, row readout, done pulse.
module systolic_ctrl #(
  parameter int ARRAY_SIZE = 4,
  parameter int KLEN_W     = 8,
  parameter int IDX_W      = 8
) (
  input logic          clk,
  input logic          rst,
  systolic_ctrl_if.slave ctl
);
  localparam int N  = ARRAY_SIZE;
  localparam int RW = $clog2(N);
  localparam logic [9:0]    DRAIN    = 10'(2*N-3);
  localparam logic [RW-1:0] LAST_ROW = RW'(N-1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, COMPUTE, OUTPUT, FIN
  } state_e;

  state_e            state_q, state_d;
  logic [9:0]        t_q, t_d;
  logic [KLEN_W-1:0] k_q, k_d;
  logic [RW-1:0]     row_q, row_d;
  logic              clr_q;
  logic [9:0]        t_last;

  assign t_last = 10'(k_q) + DRAIN;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      clr_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      k_q     <= k_d;
      row_q   <= row_d;
      clr_q   <= (state_d == CLEAR);
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    k_d     = k_q;
    row_d   = row_q;
    unique case (state_q)
      IDLE: begin
        if (ctl.start) begin
          state_d = CLEAR;
          k_d     = ctl.k_len;
          t_d     = '0;
          row_d   = '0;
        end
      end
      CLEAR: begin
        t_d     = '0;
        row_d   = '0;
        state_d = (k_q != '0) ? COMPUTE : OUTPUT;
      end
      COMPUTE: begin
        if (t_q == t_last) begin
          state_d = OUTPUT;
          t_d     = '0;
        end else begin
          t_d = t_q + 10'd1;
        end
      end
      OUTPUT: begin
        if (ctl.out_ready) begin
          if (row_q == LAST_ROW) begin
            state_d = FIN;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane i is live for k_reg cycles starting at t=i (diagonal skew).
  logic [N-1:0]       vld_w;
  logic [N*IDX_W-1:0] lk_w;

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [9:0] off;
    assign off = t_q - 10'(i);
    assign vld_w[i] = (state_q == COMPUTE)
                    && (t_q >= 10'(i))
                    && (off < 10'(k_q));
    assign lk_w[i*IDX_W +: IDX_W] =
      vld_w[i] ? IDX_W'(off) : '0;
  end

  assign ctl.busy      = (state_q != IDLE);
  assign ctl.pe_clr    = clr_q;
  assign ctl.lane_vld  = vld_w;
  assign ctl.lane_k    = lk_w;
  assign ctl.out_valid = (state_q == OUTPUT);
  assign ctl.out_row   = row_q;
  assign ctl.done      = (state_q == FIN);
endmodule

// File: tb/tb_systolic_ctrl.sv
// Randomized trace check of systolic_ctrl against a per-pass
// expected-cycle schedule built from the pass rules.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int IW = 8;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_ctrl_if #(.N(N), .KLEN_W(KW), .IDX_W(IW)) ifc ();

  systolic_ctrl #(
    .ARRAY_SIZE(N),
    .KLEN_W    (KW),
    .IDX_W     (IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ctl(ifc)
  );

  typedef struct {
    bit          rs;
    bit          st;
    bit          rdy;
    bit [KW-1:0] kl;
    bit          busy;
    bit          clr;
    bit          ov;
    bit          dn;
    bit          crow;
    bit [N-1:0]  vld;
    bit [N*IW-1:0] lk;
    bit [RW-1:0] row;
  } cyc_t;

  cyc_t tr[$];
  int n_tests  = 0;
  int n_fail   = 0;
  int exp_done = 0;
  int got_done = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t e;
    e.rs   = 1'b0;
    e.st   = 1'b0;
    e.rdy  = 1'($urandom % 2);
    e.kl   = KW'($urandom);
    e.busy = 1'b0;
    e.clr  = 1'b0;
    e.ov   = 1'b0;
    e.dn   = 1'b0;
    e.crow = 1'b0;
    e.vld  = '0;
    e.lk   = '0;
    e.row  = '0;
    return e;
  endfunction

  // Cycle spent in reset; drv says whether rst stays high for the next edge.
  function automatic cyc_t rst_entry(input bit drv);
    cyc_t e;
    e      = blank();
    e.clr  = 1'b1;
    e.crow = 1'b1;
    e.rs   = drv;
    e.st   = drv ? 1'($urandom % 2) : 1'b0;
    return e;
  endfunction

  // mode 0: ready always high; 1: 5-cycle stall at row 2; 2: random ready.
  task automatic add_pass(input int k, input int mode, input int abort_t);
    cyc_t e;
    int r;
    int stall;
    e    = blank();
    e.st = 1'b1;
    e.kl = KW'(k);
    tr.push_back(e);
    e      = blank();
    e.busy = 1'b1;
    e.clr  = 1'b1;
    e.st   = 1'($urandom % 2);
    tr.push_back(e);
    if (k > 0) begin
      for (int tt = 0; tt <= k + 2*N - 3; tt++) begin
        e      = blank();
        e.busy = 1'b1;
        e.st   = 1'($urandom % 2);
        for (int i = 0; i < N; i++) begin
          if (tt >= i && tt < i + k) begin
            e.vld[i] = 1'b1;
            e.lk[i*IW +: IW] = IW'(tt - i);
          end
        end
        if (tt == abort_t) begin
          e.rs = 1'b1;
          tr.push_back(e);
          tr.push_back(rst_entry(1'b1));
          tr.push_back(rst_entry(1'b0));
          e    = blank();
          e.st = 1'b0;
          tr.push_back(e);
          return;
        end
        tr.push_back(e);
      end
    end
    r     = 0;
    stall = 0;
    while (r < N) begin
      e      = blank();
      e.busy = 1'b1;
      e.ov   = 1'b1;
      e.crow = 1'b1;
      e.row  = RW'(r);
      e.st   = 1'($urandom % 2);
      case (mode)
        0: e.rdy = 1'b1;
        1: begin
          if (r == 2 && stall < 5) begin
            e.rdy = 1'b0;
            stall++;
          end else begin
            e.rdy = 1'b1;
          end
        end
        default: e.rdy = 1'($urandom % 3 != 0);
      endcase
      tr.push_back(e);
      if (e.rdy) r++;
    end
    e      = blank();
    e.busy = 1'b1;
    e.dn   = 1'b1;
    e.st   = 1'b1;
    tr.push_back(e);
    exp_done++;
  endtask

  initial begin
    cyc_t e;
    ifc.start     = 1'b0;
    ifc.k_len     = '0;
    ifc.out_ready = 1'b0;

    tr.push_back(rst_entry(1'b1));
    tr.push_back(rst_entry(1'b0));
    e    = blank();
    e.st = 1'b0;
    tr.push_back(e);
    add_pass(3, 0, -1);
    add_pass(3, 1, -1);
    add_pass(0, 0, -1);
    add_pass(3, 0, 5);
    add_pass(2, 0, -1);
    repeat (6) add_pass(int'($urandom_range(0, 12)), 2, -1);
    e    = blank();
    e.st = 1'b0;
    tr.push_back(e);

    foreach (tr[j]) begin
      @(negedge clk);
      e = tr[j];
      chk($sformatf("c%0d busy", j), 64'(ifc.busy), 64'(e.busy));
      chk($sformatf("c%0d pe_clr", j), 64'(ifc.pe_clr), 64'(e.clr));
      chk($sformatf("c%0d lane_vld", j), 64'(ifc.lane_vld), 64'(e.vld));
      chk($sformatf("c%0d lane_k", j), 64'(ifc.lane_k), 64'(e.lk));
      chk($sformatf("c%0d out_valid", j), 64'(ifc.out_valid), 64'(e.ov));
      chk($sformatf("c%0d done", j), 64'(ifc.done), 64'(e.dn));
      if (e.crow)
        chk($sformatf("c%0d out_row", j), 64'(ifc.out_row), 64'(e.row));
      if (ifc.done === 1'b1) got_done++;
      rst           = e.rs;
      ifc.start     = e.st;
      ifc.k_len     = e.kl;
      ifc.out_ready = e.rdy;
    end
    chk("done_count", 64'(got_done), 64'(exp_done));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
